updown_sweep_ctrl: RTL

- Controller that sequences an external up/down counter (mode_i = 1 up, 0 down; clk_i domain) through programmed triangular sweeps between lo and hi.
- Drives the counter's load/enable/mode, observes the counter's registered output, counts completed sweeps, and reports done/error.
- Sits between the test/config logic and the counter datapath.

---
 rtl/updown_sweep_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/updown_sweep_ctrl.sv
// Triangular sweep sequencer for an external up/down counter.
// Optional turning-point dwell: define SWEEP_DWELL_EN.
module updown_sweep_ctrl #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned SWEEP_W = 8,
    parameter int unsigned DWELL   = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [WIDTH-1:0]   lo_i,
    input  logic [WIDTH-1:0]   hi_i,
    input  logic [SWEEP_W-1:0] nsweeps_i,
    input  logic [WIDTH-1:0]   cnt_i,
    output logic               load_o,
    output logic [WIDTH-1:0]   load_val_o,
    output logic               cnt_en_o,
    output logic               mode_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [SWEEP_W-1:0] sweep_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DOWN,
        S_DONE
`ifdef SWEEP_DWELL_EN
        , S_DWELL
`endif
    } state_t;

    localparam logic [SWEEP_W-1:0] SW_ONE = 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [SWEEP_W-1:0] ns_q, ns_d;
    logic [SWEEP_W-1:0] sweep_q, sweep_d;
    logic [SWEEP_W-1:0] sweep_inc;

`ifdef SWEEP_DWELL_EN
    localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DW_INIT = DW_W'(DWELL - 1);
    localparam logic [DW_W-1:0] DW_ONE  = 1;

    logic [DW_W-1:0] dwell_q, dwell_d;
    logic            dir_q, dir_d;
`endif

    assign load_val_o  = lo_q;
    assign sweep_cnt_o = sweep_q;
    assign sweep_inc   = sweep_q + SW_ONE;

    // State, captured limits and sweep counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            ns_q    <= '0;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            ns_q    <= ns_d;
            sweep_q <= sweep_d;
        end
    end

`ifdef SWEEP_DWELL_EN
    // Dwell countdown and post-dwell direction
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dwell_q <= '0;
            dir_q   <= 1'b0;
        end else begin
            dwell_q <= dwell_d;
            dir_q   <= dir_d;
        end
    end
`endif

    // Next-state and counter control; abort overrides every busy state
    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        ns_d     = ns_q;
        sweep_d  = sweep_q;
        load_o   = 1'b0;
        cnt_en_o = 1'b0;
        mode_o   = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        err_o    = 1'b0;
`ifdef SWEEP_DWELL_EN
        dwell_d  = dwell_q;
        dir_d    = dir_q;
`endif
        if (abort_i && state_q != S_IDLE) begin
            busy_o  = (state_q != S_DONE);
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        if (lo_i < hi_i) begin
                            lo_d    = lo_i;
                            hi_d    = hi_i;
                            ns_d    = nsweeps_i;
                            sweep_d = '0;
                            state_d = S_LOAD;
                        end else begin
                            err_o = rst_i;
                        end
                    end
                end
                S_LOAD: begin
                    busy_o  = 1'b1;
                    load_o  = 1'b1;
                    state_d = S_UP;
                end
                S_UP: begin
                    busy_o = 1'b1;
                    if (cnt_i > hi_q) begin
                        err_o   = 1'b1;
                        state_d = S_IDLE;
                    end else if (cnt_i == hi_q) begin
`ifdef SWEEP_DWELL_EN
                        dwell_d = DW_INIT;
                        dir_d   = 1'b0;
                        state_d = S_DWELL;
`else
                        cnt_en_o = 1'b1;
                        state_d  = S_DOWN;
`endif
                    end else begin
                        cnt_en_o = 1'b1;
                        mode_o   = 1'b1;
                    end
                end
                S_DOWN: begin
                    busy_o = 1'b1;
                    if (cnt_i < lo_q) begin
                        err_o   = 1'b1;
                        state_d = S_IDLE;
                    end else if (cnt_i == lo_q) begin
                        sweep_d = sweep_inc;
                        if (ns_q != '0 && sweep_inc == ns_q) begin
                            state_d = S_DONE;
                        end else begin
`ifdef SWEEP_DWELL_EN
                            dwell_d = DW_INIT;
                            dir_d   = 1'b1;
                            state_d = S_DWELL;
`else
                            cnt_en_o = 1'b1;
                            mode_o   = 1'b1;
                            state_d  = S_UP;
`endif
                        end
                    end else begin
                        cnt_en_o = 1'b1;
                    end
                end
`ifdef SWEEP_DWELL_EN
                S_DWELL: begin
                    busy_o = 1'b1;
                    mode_o = dir_q;
                    if (dwell_q == '0) begin
                        cnt_en_o = 1'b1;
                        state_d  = dir_q ? S_UP : S_DOWN;
                    end else begin
                        dwell_d = dwell_q - DW_ONE;
                    end
                end
`endif
                S_DONE: begin
                    done_o  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule
